regfile_wr_ctrl: RTL and testbench

Write-port controller for the lab register bank. It shares the bank's single write port between two requesters (A, B) using round-robin arbitration with a valid/ready handshake. It also runs a clear sequence that writes zero to every register, both after reset and on request. Its registered outputs drive the bank's write address, write data and write-enable inputs directly; the read ports are not touched.

---
 rtl/regfile_wr_ctrl.sv | 104 ++++++++++
 tb/tb_regfile_wr_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_ctrl.sv
// Round-robin write-port arbiter for A/B plus a zero-fill clear sequence; one write per cycle.
// Writes land on rf_* one edge after acceptance; the ready signals stall a requester that loses arbitration or arrives during a clear.
module regfile_wr_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic                last_b, last_b_nxt;
  logic                we_nxt, done_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                arb_ok;

  // last_b set means B won last, so A takes the next tie
  assign arb_ok  = (state == RUN) && !clr_req;
  assign a_ready = arb_ok && a_valid && (!b_valid || last_b);
  assign b_ready = arb_ok && b_valid && (!a_valid || !last_b);
  assign busy    = (state == CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR;
      cnt      <= '0;
      last_b   <= 1'b1;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_b   <= last_b_nxt;
      rf_we    <= we_nxt;
      rf_addr  <= addr_nxt;
      rf_data  <= data_nxt;
      clr_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_b_nxt = last_b;
    we_nxt     = 1'b0;
    addr_nxt   = rf_addr;
    data_nxt   = rf_data;
    done_nxt   = 1'b0;
    case (state)
      CLEAR: begin
        we_nxt   = 1'b1;
        addr_nxt = cnt;
        data_nxt = '0;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST) begin
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end else if (a_ready) begin
          addr_nxt   = a_addr;
          data_nxt   = a_data;
          we_nxt     = (a_addr != '0);
          last_b_nxt = 1'b0;
        end else if (b_ready) begin
          // register 0 is hardwired zero: accept but suppress the write
          addr_nxt   = b_addr;
          data_nxt   = b_data;
          we_nxt     = (b_addr != '0);
          last_b_nxt = 1'b1;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Bench for regfile_wr_ctrl: vector table, hand sequences for clear/reset, randomized traffic vs reference model.
module tb_regfile_wr_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              a_valid = 1'b0, b_valid = 1'b0, clr_req = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic              a_ready, b_ready, busy, clr_done, rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  int checks = 0;
  int errors = 0;

  // reference model: remaining clear writes, who won last, expected registered outputs
  int m_left;
  bit m_last_b;
  int m_we, m_addr, m_data, m_done;
  int m_win;

  always #5 clk = ~clk;

  regfile_wr_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  typedef struct {
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              bv;
    logic [ADDR_W-1:0] ba;
    logic [DATA_W-1:0] bd;
    logic              ear;
    logic              ebr;
    logic              ewe;
    logic [ADDR_W-1:0] eaddr;
    logic [DATA_W-1:0] edata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left   = DEPTH;
    m_last_b = 1'b1;
    m_we = 0; m_addr = 0; m_data = 0; m_done = 0;
    m_win = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rf_we", int'(rf_we), 0);
    chk("rst_rf_addr", int'(rf_addr), 0);
    chk("rst_rf_data", int'(rf_data), 0);
    chk("rst_clr_done", int'(clr_done), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_a_ready", int'(a_ready), 0);
    chk("rst_b_ready", int'(b_ready), 0);
  endtask

  // one clock: check readies/busy, advance model at the edge, check registered outputs
  task automatic step(output logic ar, output logic br);
    int win;
    #1;
    win = 0;
    if (m_left == 0 && !clr_req) begin
      if (a_valid && b_valid) win = m_last_b ? 1 : 2;
      else if (a_valid)       win = 1;
      else if (b_valid)       win = 2;
    end
    ar = a_ready;
    br = b_ready;
    chk("a_ready", int'(a_ready), int'(win == 1));
    chk("b_ready", int'(b_ready), int'(win == 2));
    chk("busy", int'(busy), int'(m_left != 0));
    @(posedge clk);
    if (m_left != 0) begin
      m_we   = 1;
      m_addr = DEPTH - m_left;
      m_data = 0;
      m_done = int'(m_left == 1);
      m_left--;
    end else begin
      m_done = 0;
      m_we   = 0;
      if (clr_req) m_left = DEPTH;
      else if (win == 1) begin
        m_addr = int'(a_addr); m_data = int'(a_data);
        m_we = int'(a_addr != 0); m_last_b = 1'b0;
      end else if (win == 2) begin
        m_addr = int'(b_addr); m_data = int'(b_data);
        m_we = int'(b_addr != 0); m_last_b = 1'b1;
      end
    end
    m_win = win;
    #1;
    chk("rf_we", int'(rf_we), m_we);
    chk("rf_addr", int'(rf_addr), m_addr);
    chk("rf_data", int'(rf_data), m_data);
    chk("clr_done", int'(clr_done), m_done);
  endtask

  task automatic run_clear(input string tag);
    logic ar, br;
    for (int i = 0; i < DEPTH; i++) begin
      step(ar, br);
      chk({tag, "_ready"}, int'(ar), 0);
      chk({tag, "_addr"}, int'(rf_addr), i);
      chk({tag, "_we"}, int'(rf_we), 1);
      chk({tag, "_done"}, int'(clr_done), int'(i == DEPTH - 1));
    end
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    logic ar, br;

    vecs[0] = '{1'b1, 5'd1, 8'h11, 1'b1, 5'd2, 8'h22, 1'b1, 1'b0, 1'b1, 5'd1, 8'h11};
    vecs[1] = '{1'b1, 5'd1, 8'h11, 1'b1, 5'd2, 8'h22, 1'b0, 1'b1, 1'b1, 5'd2, 8'h22};
    vecs[2] = '{1'b1, 5'd1, 8'h11, 1'b1, 5'd2, 8'h22, 1'b1, 1'b0, 1'b1, 5'd1, 8'h11};
    vecs[3] = '{1'b1, 5'd1, 8'h11, 1'b1, 5'd2, 8'h22, 1'b0, 1'b1, 1'b1, 5'd2, 8'h22};
    vecs[4] = '{1'b1, 5'd3, 8'h5A, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd3, 8'h5A};
    vecs[5] = '{1'b0, 5'd0, 8'h00, 1'b1, 5'd0, 8'hFF, 1'b0, 1'b1, 1'b0, 5'd0, 8'hFF};
    vecs[6] = '{1'b1, 5'd1, 8'h11, 1'b1, 5'd2, 8'h22, 1'b1, 1'b0, 1'b1, 5'd1, 8'h11};
    vecs[7] = '{1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 8'h11};
    vecs[8] = '{1'b1, 5'd0, 8'h33, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'h33};
    vecs[9] = '{1'b1, 5'd1, 8'h11, 1'b1, 5'd2, 8'h22, 1'b0, 1'b1, 1'b1, 5'd2, 8'h22};

    // reset state, then the power-on clear
    model_reset();
    #12;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    run_clear("clr0");

    // arbitration vectors
    for (int i = 0; i < 10; i++) begin
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      step(ar, br);
      chk($sformatf("vec%0d_a_ready", i), int'(ar), int'(vecs[i].ear));
      chk($sformatf("vec%0d_b_ready", i), int'(br), int'(vecs[i].ebr));
      chk($sformatf("vec%0d_rf_we", i), int'(rf_we), int'(vecs[i].ewe));
      chk($sformatf("vec%0d_rf_addr", i), int'(rf_addr), int'(vecs[i].eaddr));
      chk($sformatf("vec%0d_rf_data", i), int'(rf_data), int'(vecs[i].edata));
    end

    // clear request colliding with a pending write
    a_valid = 1'b1; a_addr = 5'd5; a_data = 8'h77;
    b_valid = 1'b0; clr_req = 1'b1;
    step(ar, br);
    chk("clrreq_a_ready", int'(ar), 0);
    chk("clrreq_rf_we", int'(rf_we), 0);
    chk("clrreq_busy", int'(busy), 1);
    clr_req = 1'b0;
    run_clear("clr1");
    step(ar, br);
    chk("postclr_a_ready", int'(ar), 1);
    chk("postclr_rf_we", int'(rf_we), 1);
    chk("postclr_rf_addr", int'(rf_addr), 5);
    chk("postclr_rf_data", int'(rf_data), 'h77);
    a_valid = 1'b0;

    // randomized traffic, requests held until accepted
    for (int i = 0; i < 600; i++) begin
      if (!a_valid && ($urandom % 3 == 0)) begin
        a_valid = 1'b1; a_addr = ADDR_W'($urandom); a_data = DATA_W'($urandom);
      end
      if (!b_valid && ($urandom % 3 == 0)) begin
        b_valid = 1'b1; b_addr = ADDR_W'($urandom); b_data = DATA_W'($urandom);
      end
      clr_req = ($urandom % 50 == 0);
      step(ar, br);
      if (m_win == 1) a_valid = 1'b0;
      if (m_win == 2) b_valid = 1'b0;
    end
    a_valid = 1'b0; b_valid = 1'b0; clr_req = 1'b0;

    // asynchronous reset in the middle of a clear
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step(ar, br);
    a_valid = 1'b1; a_addr = 5'd9; a_data = 8'h99;
    #3;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    run_clear("clr2");
    step(ar, br);
    chk("final_a_ready", int'(ar), 1);
    chk("final_rf_addr", int'(rf_addr), 9);
    a_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
